// File: rtl/shift_add_multiplier4.sv
// shift_add_multiplier4
// Sequential 4x4 unsigned shift-and-add multiplier wrapped around an external
// combinational 4-bit ripple adder. The adder operands are driven from the
// accumulator and the multiplicand; the adder sum and carry come back in the
// same cycle and are shifted into {acc, q}. Four iterations produce an 8-bit
// product, presented with a start/done handshake.

module shift_add_multiplier4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] multiplicand,
    input  logic [3:0] multiplier,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    output logic       add_cin,
    input  logic [3:0] add_s,
    input  logic       add_cout,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Architectural registers
    state_t      state_r;
    logic [3:0]  m_r;
    logic [3:0]  q_r;
    logic [3:0]  acc_r;
    logic [1:0]  cnt_r;
    logic [7:0]  product_r;
    logic        busy_r;
    logic        done_r;

    // Next-state values
    state_t      state_s;
    logic [3:0]  m_s;
    logic [3:0]  q_s;
    logic [3:0]  acc_s;
    logic [1:0]  cnt_s;
    logic [7:0]  product_s;
    logic        busy_s;
    logic        done_s;

    // Adder result concatenated with the shifted multiplier: the carry-out is
    // the fifth bit of the partial sum and lands in acc[3] after the shift.
    logic [7:0]  sum_shift_s;

    assign sum_shift_s = {add_cout, add_s, q_r[3:1]};

    // Adder drive: active only while iterating so the adder is quiet otherwise
    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state_r == RUN) begin
            add_a = acc_r;
            if (q_r[0]) begin
                add_b = m_r;
            end else begin
                add_b = 4'h0;
            end
        end else begin
            add_a = 4'h0;
            add_b = 4'h0;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_s   = state_r;
        m_s       = m_r;
        q_s       = q_r;
        acc_s     = acc_r;
        cnt_s     = cnt_r;
        product_s = product_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    m_s     = multiplicand;
                    q_s     = multiplier;
                    acc_s   = 4'h0;
                    cnt_s   = 2'd0;
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                {acc_s, q_s} = sum_shift_s;
                cnt_s        = cnt_r + 2'd1;
                if (cnt_r == 2'd3) begin
                    product_s = sum_shift_s;
                    state_s   = DONE;
                end else begin
                    state_s   = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                // Unreachable encoding: recover to a clean idle state
                state_s = IDLE;
                m_s     = 4'h0;
                q_s     = 4'h0;
                acc_s   = 4'h0;
                cnt_s   = 2'd0;
            end
        endcase
        // Status flags are registered from the next state so they line up
        // with the state they describe.
        busy_s = (state_s != IDLE);
        done_s = (state_s == DONE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            m_r       <= 4'h0;
            q_r       <= 4'h0;
            acc_r     <= 4'h0;
            cnt_r     <= 2'd0;
            product_r <= 8'h00;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            m_r       <= m_s;
            q_r       <= q_s;
            acc_r     <= acc_s;
            cnt_r     <= cnt_s;
            product_r <= product_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: tb/tb_shift_add_multiplier4.sv
// Testbench for shift_add_multiplier4: models the external ripple adder,
// drives directed and random multiplies, and checks products through a
// scoreboard queue consumed by an independent monitor on each done pulse.

module tb_shift_add_multiplier4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] multiplicand;
    logic [3:0] multiplier;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_cin;
    logic [3:0] add_s;
    logic       add_cout;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int n_cmp;
    int n_err;

    logic [7:0] exp_q[$];
    logic [3:0] addb_log [0:3];
    logic       cout_seen;

    shift_add_multiplier4 dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_cin      (add_cin),
        .add_s        (add_s),
        .add_cout     (add_cout),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    // Behavioural 4-bit adder returning sum and carry combinationally
    logic [4:0] adder_sum;
    assign adder_sum = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};
    assign add_s     = adder_sum[3:0];
    assign add_cout  = adder_sum[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding product
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: product 0x%0h with no outstanding request at %0t", product, $time);
            end else begin
                check("product", {24'h0, product}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // Wait (at falling edges) until the multiplier is idle, bounded
    task automatic wait_idle();
        int budget;
        budget = 0;
        while (busy !== 1'b0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (busy !== 1'b0) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: busy=%0b expected 0 within 50 cycles", busy);
        end
    endtask

    // Issue one multiply in cycle 0 and check busy/done over cycles 1..6
    task automatic issue(input logic [3:0] mi, input logic [3:0] qi);
        int p;
        wait_idle();
        start        = 1'b1;
        multiplicand = mi;
        multiplier   = qi;
        p = int'(mi) * int'(qi);
        exp_q.push_back(p[7:0]);
        cout_seen = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start        = 1'b0;
                multiplicand = 4'($urandom);
                multiplier   = 4'($urandom);
            end
            check("busy_timing", {31'h0, busy}, {31'h0, (c <= 5)});
            check("done_timing", {31'h0, done}, {31'h0, (c == 5)});
            if (c <= 4) begin
                addb_log[c-1] = add_b;
                cout_seen     = cout_seen | add_cout;
            end
        end
    endtask

    initial begin
        int budget;
        logic [3:0] rm;
        logic [3:0] rq;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        start = 1'b0;
        multiplicand = 4'h0;
        multiplier = 4'h0;

        // Reset for two cycles, then check reset outputs
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_product", {24'h0, product}, 32'h0);
        check("rst_add_a", {28'h0, add_a}, 32'h0);
        check("rst_add_b", {28'h0, add_b}, 32'h0);
        check("rst_add_cin", {31'h0, add_cin}, 32'h0);

        // 0 x 0
        issue(4'd0, 4'd0);

        // Max operands: carry must appear in some iteration
        issue(4'd15, 4'd15);
        check("max_cout_seen", {31'h0, cout_seen}, 32'h1);

        // Mixed bits: add_b follows multiplier bits LSB-first
        issue(4'd13, 4'd11);
        for (int i = 0; i < 4; i++) begin
            rq = 4'd11;
            check("mixed_add_b", {28'h0, addb_log[i]}, {28'h0, (rq[i] ? 4'd13 : 4'd0)});
        end

        // Busy ignore: restarts during RUN and DONE are dropped
        wait_idle();
        start = 1'b1; multiplicand = 4'd3; multiplier = 4'd5;
        exp_q.push_back(8'h0F);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check("ign_done", {31'h0, done}, {31'h0, (c == 5)});
            if (c == 2 || c == 5 || c == 6) begin
                start = 1'b1; multiplicand = 4'd9; multiplier = 4'd9;
            end else begin
                start = 1'b0;
            end
        end
        check("ign_idle_c6", {31'h0, busy}, 32'h0);
        exp_q.push_back(8'h51);
        for (int c = 7; c <= 11; c++) begin
            @(negedge clk);
            start = 1'b0;
            check("ign_second_done", {31'h0, done}, {31'h0, (c == 11)});
        end

        // Reset mid-operation: the in-flight multiply is discarded
        wait_idle();
        start = 1'b1; multiplicand = 4'd7; multiplier = 4'd7;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_done", {31'h0, done}, 32'h0);
        check("midrst_product", {24'h0, product}, 32'h0);
        repeat (4) @(negedge clk);
        check("midrst_product_hold", {24'h0, product}, 32'h0);
        issue(4'd2, 4'd3);

        // Product hold with start low
        issue(4'd6, 4'd5);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("hold_product", {24'h0, product}, 32'h1E);
            check("hold_done", {31'h0, done}, 32'h0);
        end

        // Randomized multiplies, with occasional idle gaps
        for (int k = 0; k < 40; k++) begin
            rm = 4'($urandom);
            rq = 4'($urandom);
            issue(rm, rq);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Drain the scoreboard, bounded
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("scoreboard_drained", exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
